// File: rtl/dma_rd_stage.sv
// Read stage behind the 2-D DMA address generator: issues 1-cycle-latency SRAM
// reads and returns data+sideband in order through a credit-checked return FIFO.
module dma_rd_stage #(
    parameter int unsigned AW    = 14,
    parameter int unsigned IFW   = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  m_addr,
    input  logic [IFW-1:0] m_info,
    input  logic           m_first,
    input  logic           m_last,
    input  logic           m_valid,
    output logic           m_ready,
    output logic           mem_ren,
    output logic [AW-1:0]  mem_addr,
    input  logic [DW-1:0]  mem_rdata,
    output logic [DW-1:0]  s_data,
    output logic [IFW-1:0] s_info,
    output logic           s_first,
    output logic           s_last,
    output logic           s_valid,
    input  logic           s_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = DW + IFW + 2;
    localparam logic [CW-1:0] OCC_MAX  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [EW-1:0]  r_mem [DEPTH];
    logic [CW-1:0]  r_occ;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic           r_inflight;
    logic [IFW-1:0] r_if_info;
    logic           r_if_first;
    logic           r_if_last;

    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_occ_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [PW-1:0]  w_wptr_nxt;
    logic [PW-1:0]  w_rptr_nxt;
    logic [EW-1:0]  w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit: one slot per in-flight or buffered read, so a returning word always has room.
    assign m_ready  = !rst && (r_occ < OCC_MAX);
    assign w_accept = m_valid && m_ready;
    assign mem_ren  = w_accept;
    assign mem_addr = m_addr;

    assign w_push  = r_inflight;
    assign s_valid = (r_cnt != '0);
    assign w_pop   = s_valid && s_ready;

    assign w_head = r_mem[r_rptr];
    assign {s_data, s_info, s_first, s_last} = w_head;

    // Next-state for occupancy, FIFO count and pointers.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_cnt_nxt  = r_cnt;
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        case ({w_accept, w_pop})
            2'b10:   w_occ_nxt = r_occ + CW'(1);
            2'b01:   w_occ_nxt = r_occ - CW'(1);
            default: w_occ_nxt = r_occ;
        endcase
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
        if (w_push) begin
            w_wptr_nxt = ptr_inc(r_wptr);
        end
        if (w_pop) begin
            w_rptr_nxt = ptr_inc(r_rptr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= '0;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_inflight <= w_accept;
        end
    end

    // Sideband travels alongside the read for the one cycle of SRAM latency.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_if_info  <= m_info;
            r_if_first <= m_first;
            r_if_last  <= m_last;
        end
    end

    // Storage is not reset; contents are only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= {mem_rdata, r_if_info, r_if_first, r_if_last};
        end
    end

    a_m_stable : assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_addr) && $stable(m_info)
                                   && $stable(m_first) && $stable(m_last)));

    a_occ_max : assert property (@(posedge clk) disable iff (rst)
        r_occ <= OCC_MAX);

    a_no_full_push : assert property (@(posedge clk) disable iff (rst)
        (w_push && !w_pop) |-> (r_cnt < OCC_MAX));

endmodule

// File: doc/dma_rd_stage.md
Name: dma_rd_stage

Overview:
- Read stage that sits directly downstream of the 2-D DMA address generator.
- Consumes the generator's address/info/first/last stream and issues reads to a single-port SRAM with fixed 1-cycle read latency.
- Returns each read word, paired with its sideband, on a valid/ready stream to the compute datapath.
- Holds a credit-checked return FIFO so SRAM reads are never lost under downstream backpressure, and sustains one word per cycle.

Parameters:
- AW, 14, address width; matches the address generator.
- IFW, 4, info sideband width, passed through untouched.
- DW, 32, SRAM read data width.
- DEPTH, 4, return FIFO entries; also the cap on in-flight plus buffered reads. Legal range 3..16; 3 is the minimum for full throughput.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_addr  in  AW  read address from the address generator.
- m_info  in  IFW  sideband from the address generator.
- m_first  in  1  first-of-block flag.
- m_last  in  1  last-of-block flag.
- m_valid  in  1  request valid.
- m_ready  out  1  request accepted when m_valid && m_ready.
- mem_ren  out  1  SRAM read enable.
- mem_addr  out  AW  SRAM read address.
- mem_rdata  in  DW  SRAM data; valid the cycle after mem_ren.
- s_data  out  DW  returned word.
- s_info  out  IFW  sideband of the returned word.
- s_first  out  1  first flag of the returned word.
- s_last  out  1  last flag of the returned word.
- s_valid  out  1  output valid.
- s_ready  in  1  consumer ready.

Behaviour:
- Occupancy: occ = in-flight reads (0 or 1) + FIFO entries. Counter width is clog2(DEPTH+1).
- m_ready = (occ < DEPTH). It depends on registered state only; there is no combinational path from s_ready or m_valid.
- Accept: mem_ren = m_valid && m_ready and mem_addr = m_addr, both combinational. They are never asserted while m_ready=0.
- In-flight register: on accept, {m_info, m_first, m_last} and the in-flight bit are registered. On the next cycle mem_rdata is sampled together with the registered sideband and written into the FIFO at that cycle's edge.
- Ordering: strictly in order. The FIFO write pointer wraps modulo DEPTH; the read pointer wraps independently.
- Output: s_valid = FIFO non-empty. s_data/s_info/s_first/s_last show the FIFO head combinationally from the storage array. They hold stable while s_valid && !s_ready.
- Pop: the head is popped on s_valid && s_ready.
- Latency: accept at cycle t, mem_rdata at t+1, s_valid earliest at t+2.
- Throughput: with s_ready held high, back-to-back accepts every cycle, one word out per cycle; occ settles at 2.
- Simultaneous write and pop on a full FIFO: cannot occur. The credit rule guarantees a free entry for every in-flight read.
- Simultaneous write and pop otherwise: both take effect; the FIFO count is unchanged.
- Occupancy update per cycle: occ += accept; occ -= pop. The in-flight-to-FIFO transfer is occupancy-neutral.
- Flags: first/last are pass-through only; no block counting is done here.
- Reset values: m_ready=0 during the rst cycle; s_valid=0; mem_ren=0; in-flight bit=0; FIFO pointers and count=0.
- FIFO data array: not reset. s_data/s_info/s_first/s_last are don't-care while s_valid=0.
- Reset mid-operation: all in-flight and buffered words are dropped. mem_rdata returning in the cycle after reset deassertion is ignored because the in-flight bit is clear. m_ready=1 from the first cycle after rst falls.
- Protocol assertions:
  - m_* is stable while m_valid && !m_ready.
  - occ never exceeds DEPTH.

Test Plan:
- Single read: SRAM model returns addr^0xA5A5_0000. Push addr=0x0010, info=0x3, first=1, last=1 with s_ready=1. mem_ren is seen at cycle t with mem_addr=0x0010. s_valid=1 at t+2 with s_data=0xA5A5_0010, s_info=3, s_first=1, s_last=1. occ returns to 0.
- Streaming: 64 addresses 0x0100..0x013F, s_ready=1. One mem_ren per cycle with no bubble; 64 outputs in order on consecutive cycles; first flag only on word 0, last flag only on word 63.
- Backpressure: stream 10 requests with s_ready=0. Exactly 4 accepted (DEPTH=4); m_ready drops after the 4th accept. Raise s_ready: all 10 words emerge in order with no loss or duplication. Check that s_data stays stable while stalled.
- Random stalls: random m_valid and s_ready at 50% for 2000 requests. Scoreboard the in-order data/info/flags. occ is never above 4, and no mem_ren occurs while m_ready=0.
- Reset mid-flight: assert rst for 1 cycle while 1 read is in flight and 3 words are buffered. s_valid=0 the next cycle, and the stale mem_rdata is not written. A new request for 0x0200 returns 0xA5A5_0200 as the only output.
- Wrap-around: DEPTH=3 build, 20 requests with s_ready toggling 1,0,0. Pointers wrap several times; order is preserved; sustained rate matches the s_ready duty cycle.
